sifted_key_compactor: RTL and testbench
=======================================

Name: sifted_key_compactor

Overview:
- Sequential, parametrised successor to the single-cycle sifted-key packer in the BB84 post-processing chain.
- Captures one raw-key frame for sender and receiver, then compacts the valid bits of each channel LSB-first over N/LANES cycles.
- Also counts positions valid on both channels and the bit errors among them, giving a QBER estimate for downstream reconciliation.
- Uses a start/ready/done handshake so the upstream sifter and downstream error-correction blocks can stall.

Parameters:
- N, 80, raw frame length in bits.
- LANES, 4, bits examined per scan cycle. Must divide N.
- LW, $clog2(N+1), width of all length and count outputs (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame request; accepted only when ready=1
- ready  out  1  high in IDLE only
- sender_sifted  in  N  sender raw bits
- sender_svalid  in  N  sender per-bit valid mask
- receiver_sifted  in  N  receiver raw bits
- receiver_svalid  in  N  receiver per-bit valid mask
- sender_vsifted  out  N  compacted sender key, LSB-first
- receiver_vsifted  out  N  compacted receiver key, LSB-first
- sender_len  out  LW  number of sender valid bits
- receiver_len  out  LW  number of receiver valid bits
- common_cnt  out  LW  count of positions where both masks are 1
- err_cnt  out  LW  count of common positions where the sender and receiver bits differ
- done  out  1  one-cycle pulse when results update

Behaviour:
- Single clock. Reset is synchronous and active-high. Every flop responds only on the rising edge of clk.
- On rst=1:
  - state goes to IDLE.
  - All outputs clear to 0 except ready, which is 1.
  - Internal working registers clear.
  - rst has priority over any other event, including mid-scan. Any in-flight frame is discarded with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE: ready=1. On start=1, at edge E0:
  - All four input vectors are captured into shadow registers. Inputs may change afterwards without effect.
  - Working packers, indices and counters clear.
  - chunk index clears to 0.
  - state goes to SCAN.
- SCAN: ready=0. At each edge, shadow bits [chunk*LANES +: LANES] are processed in ascending lane order:
  - Sender and receiver are handled independently. A valid bit is written to working[idx] and idx increments.
  - Multiple valid lanes in one cycle must pack contiguously, preserving bit order.
  - common_cnt increments per lane with both valids 1. err_cnt increments where, in addition, the sifted bits differ.
  - On the last chunk (chunk = N/LANES-1), final working values, including that chunk, load into all outputs, done is set to 1, and state goes to DONE.
- DONE: lasts one cycle, with done=1 and ready=0. Next state is IDLE, and done returns to 0.
- Latency: done is high during the cycle following edge E0 + N/LANES (default 20 edges). For N=80, LANES=4, the accept-to-accept period is 22 cycles.
- Outputs hold their previous frame's values throughout SCAN. They change only at the completing edge or on reset.
- Bits of *_vsifted at index >= *_len are 0. Previous-frame residue is never visible.
- start while ready=0 (SCAN or DONE) is ignored. It is not queued.
- Width rules:
  - Counts max out at N, which fits in LW.
  - idx never exceeds N.
  - No wrap-around is possible, since writes only occur with idx < N.
- All-zero masks: lengths and counts are 0, vectors are 0, and done still pulses.

Test Plan:
- Full valid frame. All four masks all-ones; sender_sifted = receiver_sifted = 80'hA5A5_A5A5_A5A5_A5A5_A5A5; start at E0 -> done high only in the cycle after E20. Both vsifted = 80'hA5A5_A5A5_A5A5_A5A5_A5A5. sender_len = receiver_len = common_cnt = 80, err_cnt = 0.
- Sparse packing within one chunk.
  - Inputs: sender_svalid = 80'h5, sender_sifted = 80'h1; receiver_svalid = 80'hF0, receiver_sifted = 80'hA0.
  - Expected: sender_vsifted = 80'h1, sender_len = 2. receiver_vsifted = 80'hA, receiver_len = 4. common_cnt = 0, err_cnt = 0.
- Error counting. Both masks = 80'hFF; sender_sifted = 80'h00; receiver_sifted = 80'h0B -> common_cnt = 8, err_cnt = 3, both lens = 8.
- Empty and residue frames.
  - Run the full-valid frame, then an all-zero-mask frame.
  - Expected after the second done: all lengths and counts 0, both vsifted 80'h0.
  - Outputs must still show the first frame's values during the second frame's SCAN.
- Handshake and reset.
  - start held high continuously -> frames accepted every 22 cycles. ready is low for 21 cycles per frame.
  - Separately, assert rst for one cycle at E10 of a scan -> no done pulse. ready=1 and all outputs 0 on the following cycle. A new start is then accepted normally.
- LANES sweep. Re-run the sparse and error scenarios with LANES=1, 2, 8, 16 -> identical outputs. done latency equals N/LANES.

Source files
------------

// File: rtl/sifted_key_compactor.sv
// Sequential sifted-key compactor: packs valid sender/receiver bits LSB-first
// over N/LANES cycles and counts common positions and bit errors among them.
module sifted_key_compactor #(
    parameter int N     = 80,
    parameter int LANES = 4,
    parameter int LW    = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    input  logic [N-1:0]  sender_sifted,
    input  logic [N-1:0]  sender_svalid,
    input  logic [N-1:0]  receiver_sifted,
    input  logic [N-1:0]  receiver_svalid,
    output logic [N-1:0]  sender_vsifted,
    output logic [N-1:0]  receiver_vsifted,
    output logic [LW-1:0] sender_len,
    output logic [LW-1:0] receiver_len,
    output logic [LW-1:0] common_cnt,
    output logic [LW-1:0] err_cnt,
    output logic          done
);

    localparam int CHUNKS = N / LANES;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);
    localparam logic [LW-1:0] NL = LW'(N);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t state;
    logic [CW-1:0] chunk;
    logic [N-1:0]  sh_s, sh_sv, sh_r, sh_rv;
    logic [N-1:0]  s_work, r_work;
    logic [LW-1:0] s_idx, r_idx, c_cnt, e_cnt;

    logic [N-1:0]  s_nxt, r_nxt;
    logic [LW-1:0] s_idx_nxt, r_idx_nxt, c_nxt, e_nxt;

    // Shadows shift down each scan cycle, so the current chunk is always the low LANES bits.
    always_comb begin
        s_nxt     = s_work;
        r_nxt     = r_work;
        s_idx_nxt = s_idx;
        r_idx_nxt = r_idx;
        c_nxt     = c_cnt;
        e_nxt     = e_cnt;
        for (int l = 0; l < LANES; l++) begin
            if (sh_sv[l] && (s_idx_nxt < NL)) begin
                s_nxt[s_idx_nxt] = sh_s[l];
                s_idx_nxt = s_idx_nxt + LW'(1);
            end
            if (sh_rv[l] && (r_idx_nxt < NL)) begin
                r_nxt[r_idx_nxt] = sh_r[l];
                r_idx_nxt = r_idx_nxt + LW'(1);
            end
            if (sh_sv[l] && sh_rv[l]) begin
                c_nxt = c_nxt + LW'(1);
                if (sh_s[l] != sh_r[l]) begin
                    e_nxt = e_nxt + LW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ready            <= 1'b1;
            done             <= 1'b0;
            chunk            <= '0;
            sh_s             <= '0;
            sh_sv            <= '0;
            sh_r             <= '0;
            sh_rv            <= '0;
            s_work           <= '0;
            r_work           <= '0;
            s_idx            <= '0;
            r_idx            <= '0;
            c_cnt            <= '0;
            e_cnt            <= '0;
            sender_vsifted   <= '0;
            receiver_vsifted <= '0;
            sender_len       <= '0;
            receiver_len     <= '0;
            common_cnt       <= '0;
            err_cnt          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_s   <= sender_sifted;
                        sh_sv  <= sender_svalid;
                        sh_r   <= receiver_sifted;
                        sh_rv  <= receiver_svalid;
                        s_work <= '0;
                        r_work <= '0;
                        s_idx  <= '0;
                        r_idx  <= '0;
                        c_cnt  <= '0;
                        e_cnt  <= '0;
                        chunk  <= '0;
                        ready  <= 1'b0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    sh_s   <= sh_s >> LANES;
                    sh_sv  <= sh_sv >> LANES;
                    sh_r   <= sh_r >> LANES;
                    sh_rv  <= sh_rv >> LANES;
                    s_work <= s_nxt;
                    r_work <= r_nxt;
                    s_idx  <= s_idx_nxt;
                    r_idx  <= r_idx_nxt;
                    c_cnt  <= c_nxt;
                    e_cnt  <= e_nxt;
                    chunk  <= chunk + CW'(1);
                    if (chunk == LAST) begin
                        sender_vsifted   <= s_nxt;
                        receiver_vsifted <= r_nxt;
                        sender_len       <= s_idx_nxt;
                        receiver_len     <= r_idx_nxt;
                        common_cnt       <= c_nxt;
                        err_cnt          <= e_nxt;
                        done             <= 1'b1;
                        state            <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sifted_key_compactor.sv
// Scoreboard bench for sifted_key_compactor: directed frames, handshake,
// mid-scan reset and a LANES sweep on parallel instances.
module tb_sifted_key_compactor;

    localparam int N  = 80;
    localparam int LW = $clog2(N + 1);

    typedef struct {
        logic [N-1:0] vs;
        logic [N-1:0] vr;
        int sl;
        int rl;
        int cc;
        int ec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready, done;
    logic [N-1:0] s_sf = '0, s_sv = '0, r_sf = '0, r_sv = '0;
    logic [N-1:0] vs_s, vs_r;
    logic [LW-1:0] s_len, r_len, c_cnt, e_cnt;

    logic [N-1:0]  sw_vs_s [4];
    logic [N-1:0]  sw_vs_r [4];
    logic [LW-1:0] sw_sl [4];
    logic [LW-1:0] sw_rl [4];
    logic [LW-1:0] sw_cc [4];
    logic [LW-1:0] sw_ec [4];
    logic [3:0] sw_done, sw_ready;

    exp_t q[$];
    exp_t sw_exp;
    logic sw_en = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_prev = 0;
    int acc_n = 0;
    int sw_hits = 0;
    int lowcnt = 0;
    int last_low = 0;

    always #5 clk = ~clk;

    sifted_key_compactor #(.N(N), .LANES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .sender_sifted(s_sf), .sender_svalid(s_sv),
        .receiver_sifted(r_sf), .receiver_svalid(r_sv),
        .sender_vsifted(vs_s), .receiver_vsifted(vs_r),
        .sender_len(s_len), .receiver_len(r_len),
        .common_cnt(c_cnt), .err_cnt(e_cnt), .done(done)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int LG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        sifted_key_compactor #(.N(N), .LANES(LG)) u_sw (
            .clk(clk), .rst(rst), .start(start), .ready(sw_ready[g]),
            .sender_sifted(s_sf), .sender_svalid(s_sv),
            .receiver_sifted(r_sf), .receiver_svalid(r_sv),
            .sender_vsifted(sw_vs_s[g]), .receiver_vsifted(sw_vs_r[g]),
            .sender_len(sw_sl[g]), .receiver_len(sw_rl[g]),
            .common_cnt(sw_cc[g]), .err_cnt(sw_ec[g]), .done(sw_done[g])
        );
    end

    function automatic int lanes_of(input int g);
        case (g)
            0: lanes_of = 1;
            1: lanes_of = 2;
            2: lanes_of = 8;
            default: lanes_of = 16;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && start && ready) begin
            acc_cyc  <= cyc + 1;
            acc_prev <= acc_cyc;
            acc_n    <= acc_n + 1;
        end
    end

    // Monitor: pops the scoreboard on every main done, checks sweep instances.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("vs_s", vs_s, e.vs);
                    chk("vs_r", vs_r, e.vr);
                    chk("s_len", N'(s_len), N'(e.sl));
                    chk("r_len", N'(r_len), N'(e.rl));
                    chk("common", N'(c_cnt), N'(e.cc));
                    chk("err", N'(e_cnt), N'(e.ec));
                    chk("latency", N'(cyc - acc_cyc), N'(20));
                end
            end
            if (ready === 1'b0) begin
                lowcnt = lowcnt + 1;
            end else if (lowcnt != 0) begin
                last_low = lowcnt;
                lowcnt = 0;
            end
            for (int g = 0; g < 4; g++) begin
                if (sw_en && sw_done[g] === 1'b1) begin
                    sw_hits = sw_hits + 1;
                    chk("sw_vs_s", sw_vs_s[g], sw_exp.vs);
                    chk("sw_vs_r", sw_vs_r[g], sw_exp.vr);
                    chk("sw_s_len", N'(sw_sl[g]), N'(sw_exp.sl));
                    chk("sw_r_len", N'(sw_rl[g]), N'(sw_exp.rl));
                    chk("sw_common", N'(sw_cc[g]), N'(sw_exp.cc));
                    chk("sw_err", N'(sw_ec[g]), N'(sw_exp.ec));
                    chk("sw_latency", N'(cyc - acc_cyc), N'(80 / lanes_of(g)));
                end
            end
        end
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (i < 400 && !(q.size() == 0 && ready === 1'b1 && sw_ready === 4'hF)) begin
            @(negedge clk);
            i++;
        end
        chk("drain_timeout", N'(i < 400), N'(1));
    endtask

    task automatic send(input logic [N-1:0] s, input logic [N-1:0] sv,
                        input logic [N-1:0] r, input logic [N-1:0] rv,
                        input bit push, input exp_t e);
        wait_idle();
        s_sf = s;
        s_sv = sv;
        r_sf = r;
        r_sv = rv;
        if (push) q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_sf = ~s;
        s_sv = ~sv;
        r_sf = ~r;
        r_sv = ~rv;
    endtask

    initial begin : stim
        exp_t f_full, f_sparse, f_err, f_zero;
        logic [N-1:0] a5, ones;
        int h0, b0;
        a5   = {20{4'hA, 4'h5}} >> 0;
        a5   = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
        ones = '1;
        f_full   = '{vs: a5, vr: a5, sl: 80, rl: 80, cc: 80, ec: 0};
        f_sparse = '{vs: 80'h1, vr: 80'hA, sl: 2, rl: 4, cc: 0, ec: 0};
        f_err    = '{vs: 80'h0, vr: 80'h0B, sl: 8, rl: 8, cc: 8, ec: 3};
        f_zero   = '{vs: 80'h0, vr: 80'h0, sl: 0, rl: 0, cc: 0, ec: 0};

        repeat (2) @(negedge clk);
        chk("rst_ready", N'(ready), N'(1));
        chk("rst_done", N'(done), N'(0));
        chk("rst_vs_s", vs_s, '0);
        chk("rst_len", N'({s_len, r_len, c_cnt, e_cnt}), N'(0));
        rst = 1'b0;

        send(a5, ones, a5, ones, 1'b1, f_full);
        send('0, '0, '0, '0, 1'b1, f_zero);
        repeat (5) @(negedge clk);
        chk("hold_s_len", N'(s_len), N'(80));
        chk("hold_common", N'(c_cnt), N'(80));
        chk("hold_vs_r", vs_r, a5);
        chk("hold_ready", N'(ready), N'(0));

        for (int k = 0; k < 2; k++) begin
            wait_idle();
            sw_exp = (k == 0) ? f_sparse : f_err;
            sw_en = 1'b1;
            h0 = sw_hits;
            if (k == 0) send(80'h1, 80'h5, 80'hA0, 80'hF0, 1'b1, f_sparse);
            else send(80'h0, 80'hFF, 80'h0B, 80'hFF, 1'b1, f_err);
            wait_idle();
            chk("sw_hits", N'(sw_hits - h0), N'(4));
            sw_en = 1'b0;
        end

        wait_idle();
        s_sf = 80'h1;
        s_sv = 80'h5;
        r_sf = 80'hA0;
        r_sv = 80'hF0;
        b0 = acc_n;
        repeat (3) q.push_back(f_sparse);
        start = 1'b1;
        for (int i = 0; i < 200 && acc_n != b0 + 3; i++) @(negedge clk);
        start = 1'b0;
        chk("accepts", N'(acc_n - b0), N'(3));
        chk("period", N'(acc_cyc - acc_prev), N'(22));
        wait_idle();
        chk("ready_low", N'(last_low), N'(21));

        send(a5, ones, a5, ones, 1'b0, f_full);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", N'(ready), N'(1));
        chk("mid_rst_done", N'(done), N'(0));
        chk("mid_rst_vs", vs_s | vs_r, '0);
        chk("mid_rst_cnt", N'({s_len, r_len, c_cnt, e_cnt}), N'(0));
        repeat (30) @(negedge clk);
        send(80'h0, 80'hFF, 80'h0B, 80'hFF, 1'b1, f_err);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
